// File: rtl/slsd_seg_store_if.sv
// Bus bundle for the line-segment store.
//  slave  : seen by the store (segment/control inputs in, usage stream and status out)
//  master : seen by whatever drives the store (the LSD core side and overlay consumer)
// Signals:
//  in_frame_start, in_seg_valid, in_seg_x0/x1 (H_BITW), in_seg_y0/y1 (V_BITW), in_scan_start
//  out_flag, out_valid, out_idx (ADDR_BITW), out_seg_x0/x1, out_seg_y0/y1,
//  seg_count (CNT_BITW), overflow, busy
interface slsd_seg_store_if #(
    parameter int IMAGE_HEIGHT = 480,
    parameter int IMAGE_WIDTH  = 640,
    parameter int RAM_SIZE     = 4096
);
    localparam int V_BITW    = $clog2(IMAGE_HEIGHT);
    localparam int H_BITW    = $clog2(IMAGE_WIDTH);
    localparam int ADDR_BITW = $clog2(RAM_SIZE);
    localparam int CNT_BITW  = $clog2(RAM_SIZE + 1);

    logic                 in_frame_start;
    logic                 in_seg_valid;
    logic [H_BITW-1:0]    in_seg_x0;
    logic [H_BITW-1:0]    in_seg_x1;
    logic [V_BITW-1:0]    in_seg_y0;
    logic [V_BITW-1:0]    in_seg_y1;
    logic                 in_scan_start;

    logic                 out_flag;
    logic                 out_valid;
    logic [ADDR_BITW-1:0] out_idx;
    logic [H_BITW-1:0]    out_seg_x0;
    logic [H_BITW-1:0]    out_seg_x1;
    logic [V_BITW-1:0]    out_seg_y0;
    logic [V_BITW-1:0]    out_seg_y1;
    logic [CNT_BITW-1:0]  seg_count;
    logic                 overflow;
    logic                 busy;

    modport slave (
        input  in_frame_start, in_seg_valid, in_seg_x0, in_seg_x1, in_seg_y0, in_seg_y1,
        input  in_scan_start,
        output out_flag, out_valid, out_idx, out_seg_x0, out_seg_x1, out_seg_y0, out_seg_y1,
        output seg_count, overflow, busy
    );

    modport master (
        output in_frame_start, in_seg_valid, in_seg_x0, in_seg_x1, in_seg_y0, in_seg_y1,
        output in_scan_start,
        input  out_flag, out_valid, out_idx, out_seg_x0, out_seg_x1, out_seg_y0, out_seg_y1,
        input  seg_count, overflow, busy
    );
endinterface

// File: rtl/slsd_seg_store.sv
// Per-frame line-segment store feeding the memory-usage overlay.
// Segments from the LSD core are written into a RAM_SIZE-entry RAM during a frame. A scan
// request walks every slot once and streams flag (scan window), valid (slot holds a segment
// of the current frame), the slot index and the slot contents, two cycles behind issue.
// Ports:
//  clock  : clock
//  n_rst  : synchronous active-low reset
//  bus    : slsd_seg_store_if.slave (segment input, scan control, usage stream, status)
module slsd_seg_store #(
    parameter int IMAGE_HEIGHT = 480,
    parameter int IMAGE_WIDTH  = 640,
    parameter int RAM_SIZE     = 4096
) (
    input logic             clock,
    input logic             n_rst,
    slsd_seg_store_if.slave bus
);
    localparam int V_BITW    = $clog2(IMAGE_HEIGHT);
    localparam int H_BITW    = $clog2(IMAGE_WIDTH);
    localparam int ADDR_BITW = $clog2(RAM_SIZE);
    localparam int CNT_BITW  = $clog2(RAM_SIZE + 1);
    localparam int WORD_BITW = 2 * H_BITW + 2 * V_BITW;

    // Word layout {x0, y0, x1, y1}, y1 in the LSBs.
    localparam int Y1_LSB = 0;
    localparam int X1_LSB = V_BITW;
    localparam int Y0_LSB = V_BITW + H_BITW;
    localparam int X0_LSB = 2 * V_BITW + H_BITW;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] SCAN    = 2'd2;

    localparam logic [CNT_BITW-1:0]  FULL      = CNT_BITW'(RAM_SIZE);
    localparam logic [ADDR_BITW-1:0] LAST_SLOT = ADDR_BITW'(RAM_SIZE - 1);

    logic [1:0]           state_q, state_d;
    // wr_ptr never wraps and only advances on an accepted segment, so it doubles as seg_count.
    logic [CNT_BITW-1:0]  wr_ptr_q, wr_ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 scan_pend_q, scan_pend_d;
    logic [ADDR_BITW-1:0] rd_ptr_q, rd_ptr_d;

    logic                 wr_en;
    logic [ADDR_BITW-1:0] wr_addr;
    logic [WORD_BITW-1:0] wr_word;
    logic                 issue;

    logic [WORD_BITW-1:0] mem [RAM_SIZE];
    logic [WORD_BITW-1:0] rd_word_q;

    // Stage 1: aligned with the registered RAM read.
    logic                 rd_flag_q;
    logic                 rd_hit_q;
    logic [ADDR_BITW-1:0] rd_idx_q;

    // Stage 2: output registers.
    logic                 out_flag_q;
    logic                 out_valid_q;
    logic [ADDR_BITW-1:0] out_idx_q;
    logic [H_BITW-1:0]    out_x0_q, out_x1_q;
    logic [V_BITW-1:0]    out_y0_q, out_y1_q;

    assign wr_word = {bus.in_seg_x0, bus.in_seg_y0, bus.in_seg_x1, bus.in_seg_y1};
    assign issue   = (state_q == SCAN);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        scan_pend_d = scan_pend_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_q[ADDR_BITW-1:0];

        case (state_q)
            IDLE: begin
                if (bus.in_frame_start) begin
                    state_d    = COLLECT;
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                end else if (bus.in_scan_start) begin
                    // Re-scan of the last frame; the count is kept.
                    state_d  = SCAN;
                    rd_ptr_d = '0;
                end
            end

            COLLECT: begin
                if (bus.in_frame_start) begin
                    // Restart; a coincident segment becomes the first of the new frame.
                    overflow_d = 1'b0;
                    wr_ptr_d   = '0;
                    if (bus.in_seg_valid) begin
                        wr_en    = 1'b1;
                        wr_addr  = '0;
                        wr_ptr_d = CNT_BITW'(1);
                    end
                end else begin
                    if (bus.in_seg_valid) begin
                        if (wr_ptr_q < FULL) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    // A segment in the same cycle is counted before the scan samples the count.
                    if (bus.in_scan_start) begin
                        state_d  = SCAN;
                        rd_ptr_d = '0;
                    end
                end
            end

            SCAN: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (bus.in_seg_valid) begin
                    overflow_d = 1'b1;
                end
                if (bus.in_frame_start) begin
                    scan_pend_d = 1'b1;
                end
                if (rd_ptr_q == LAST_SLOT) begin
                    rd_ptr_d = '0;
                    // A frame start on the final issue cycle is honoured as well.
                    if (scan_pend_q || bus.in_frame_start) begin
                        state_d     = COLLECT;
                        wr_ptr_d    = '0;
                        overflow_d  = 1'b0;
                        scan_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            scan_pend_q <= 1'b0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            scan_pend_q <= scan_pend_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Simple dual-port RAM, registered read, contents not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
        rd_word_q <= mem[rd_ptr_q];
    end

    // Slot occupancy is decided at issue time so the trailing outputs of a scan still reflect
    // the scanned frame even if a fresh COLLECT has already cleared the count.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            rd_flag_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
            rd_idx_q    <= '0;
            out_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_x0_q    <= '0;
            out_y0_q    <= '0;
            out_x1_q    <= '0;
            out_y1_q    <= '0;
        end else begin
            rd_flag_q   <= issue;
            rd_hit_q    <= issue && (CNT_BITW'(rd_ptr_q) < wr_ptr_q);
            rd_idx_q    <= rd_ptr_q;
            out_flag_q  <= rd_flag_q;
            out_valid_q <= rd_flag_q && rd_hit_q;
            out_idx_q   <= rd_idx_q;
            // Empty slots read back as zero rather than stale or uninitialised RAM.
            if (rd_hit_q) begin
                out_x0_q <= rd_word_q[X0_LSB +: H_BITW];
                out_y0_q <= rd_word_q[Y0_LSB +: V_BITW];
                out_x1_q <= rd_word_q[X1_LSB +: H_BITW];
                out_y1_q <= rd_word_q[Y1_LSB +: V_BITW];
            end else begin
                out_x0_q <= '0;
                out_y0_q <= '0;
                out_x1_q <= '0;
                out_y1_q <= '0;
            end
        end
    end

    assign bus.out_flag   = out_flag_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_seg_x0 = out_x0_q;
    assign bus.out_seg_y0 = out_y0_q;
    assign bus.out_seg_x1 = out_x1_q;
    assign bus.out_seg_y1 = out_y1_q;
    assign bus.seg_count  = wr_ptr_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q == SCAN);
endmodule

// File: tb/tb_slsd_seg_store.sv
// Directed bench for slsd_seg_store with RAM_SIZE=16, 640x480 image (H_BITW=10, V_BITW=9).
module tb_slsd_seg_store;
    localparam int RS = 16;
    localparam int IW = 640;
    localparam int IH = 480;

    logic clock = 1'b0;
    logic n_rst = 1'b0;
    always #5 clock = ~clock;

    slsd_seg_store_if #(.IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW), .RAM_SIZE(RS)) bus ();

    slsd_seg_store #(
        .IMAGE_HEIGHT(IH),
        .IMAGE_WIDTH (IW),
        .RAM_SIZE    (RS)
    ) dut (
        .clock(clock),
        .n_rst(n_rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0] ex0 [RS];
    logic [8:0] ey0 [RS];
    logic [9:0] ex1 [RS];
    logic [8:0] ey1 [RS];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.in_frame_start = 1'b0;
        bus.in_seg_valid   = 1'b0;
        bus.in_scan_start  = 1'b0;
        bus.in_seg_x0      = '0;
        bus.in_seg_y0      = '0;
        bus.in_seg_x1      = '0;
        bus.in_seg_y1      = '0;
    endtask

    // Present segment {base+slot, +1, +2, +3}; record it as expected content of slot if rec.
    task automatic set_seg(input int slot, input int base, input bit rec);
        logic [9:0] x0, x1;
        logic [8:0] y0, y1;
        x0 = 10'(base + slot);
        y0 = 9'(base + slot + 1);
        x1 = 10'(base + slot + 2);
        y1 = 9'(base + slot + 3);
        bus.in_seg_valid = 1'b1;
        bus.in_seg_x0    = x0;
        bus.in_seg_y0    = y0;
        bus.in_seg_x1    = x1;
        bus.in_seg_y1    = y1;
        if (rec) begin
            ex0[slot] = x0;
            ey0[slot] = y0;
            ex1[slot] = x1;
            ey1[slot] = y1;
        end
    endtask

    task automatic pulse_frame();
        bus.in_frame_start = 1'b1;
        tick();
        clear_in();
    endtask

    // Called right after the edge that moved the DUT into SCAN.
    task automatic scan_check(input string tag, input int nval, input int frame_at,
                              input int seg_at);
        chk({tag, ".busy_entry"}, 64'(bus.busy), 64'd1);
        chk({tag, ".flag_lat0"}, 64'(bus.out_flag), 64'd0);
        tick();
        chk({tag, ".flag_lat1"}, 64'(bus.out_flag), 64'd0);
        tick();
        for (int i = 0; i < RS; i++) begin
            chk($sformatf("%s.flag%0d", tag, i), 64'(bus.out_flag), 64'd1);
            chk($sformatf("%s.idx%0d", tag, i), 64'(bus.out_idx), 64'(i));
            chk($sformatf("%s.valid%0d", tag, i), 64'(bus.out_valid), (i < nval) ? 64'd1 : 64'd0);
            if (i < nval) begin
                chk($sformatf("%s.data%0d", tag, i),
                    64'({bus.out_seg_x0, bus.out_seg_y0, bus.out_seg_x1, bus.out_seg_y1}),
                    64'({ex0[i], ey0[i], ex1[i], ey1[i]}));
            end
            if (i == frame_at) bus.in_frame_start = 1'b1;
            if (i == seg_at) set_seg(9, 7, 1'b0);
            tick();
            clear_in();
        end
        chk({tag, ".flag_end"}, 64'(bus.out_flag), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        n_rst = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.flag", 64'(bus.out_flag), 64'd0);
        chk("rst.valid", 64'(bus.out_valid), 64'd0);
        chk("rst.idx", 64'(bus.out_idx), 64'd0);
        chk("rst.count", 64'(bus.seg_count), 64'd0);
        chk("rst.overflow", 64'(bus.overflow), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.data", 64'({bus.out_seg_x0, bus.out_seg_y0, bus.out_seg_x1, bus.out_seg_y1}),
            64'd0);
        n_rst = 1'b1;
        tick();

        // 1) five segments then scan
        pulse_frame();
        for (int i = 0; i < 5; i++) begin
            set_seg(i, 0, 1'b1);
            tick();
            clear_in();
        end
        chk("t1.count", 64'(bus.seg_count), 64'd5);
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        scan_check("t1", 5, -1, -1);
        chk("t1.busy_after", 64'(bus.busy), 64'd0);
        chk("t1.count_after", 64'(bus.seg_count), 64'd5);

        // 2) 20 segments into 16 slots
        pulse_frame();
        for (int i = 0; i < 20; i++) begin
            set_seg(i, 40, i < RS);
            tick();
            clear_in();
        end
        chk("t2.count", 64'(bus.seg_count), 64'd16);
        chk("t2.overflow", 64'(bus.overflow), 64'd1);
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        scan_check("t2", 16, -1, -1);

        // 3) segment coincident with scan_start at count 3
        pulse_frame();
        chk("t3.overflow_clr", 64'(bus.overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            set_seg(i, 100, 1'b1);
            tick();
            clear_in();
        end
        set_seg(3, 100, 1'b1);
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        chk("t3.count", 64'(bus.seg_count), 64'd4);
        scan_check("t3", 4, -1, -1);

        // 4) frame_start mid-scan: scan completes, then a fresh frame
        pulse_frame();
        for (int i = 0; i < 2; i++) begin
            set_seg(i, 200, 1'b1);
            tick();
            clear_in();
        end
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        scan_check("t4", 2, 5, -1);
        chk("t4.busy_after", 64'(bus.busy), 64'd0);
        chk("t4.count_fresh", 64'(bus.seg_count), 64'd0);
        set_seg(0, 300, 1'b1);
        tick();
        clear_in();
        chk("t4.count_one", 64'(bus.seg_count), 64'd1);
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        scan_check("t4b", 1, -1, -1);

        // 5) segment during SCAN is dropped (re-scan from IDLE keeps the count)
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        scan_check("t5", 1, -1, 3);
        chk("t5.overflow", 64'(bus.overflow), 64'd1);
        chk("t5.count", 64'(bus.seg_count), 64'd1);
        pulse_frame();
        chk("t5.overflow_clr", 64'(bus.overflow), 64'd0);
        chk("t5.count_clr", 64'(bus.seg_count), 64'd0);

        // 6) reset in the middle of a scan
        for (int i = 0; i < 3; i++) begin
            set_seg(i, 20, 1'b1);
            tick();
            clear_in();
        end
        bus.in_scan_start = 1'b1;
        tick();
        clear_in();
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t6.idx_before", 64'(bus.out_idx), 64'd7);
        chk("t6.flag_before", 64'(bus.out_flag), 64'd1);
        n_rst = 1'b0;
        tick();
        chk("t6.flag", 64'(bus.out_flag), 64'd0);
        chk("t6.busy", 64'(bus.busy), 64'd0);
        chk("t6.valid", 64'(bus.out_valid), 64'd0);
        chk("t6.idx", 64'(bus.out_idx), 64'd0);
        chk("t6.count", 64'(bus.seg_count), 64'd0);
        chk("t6.overflow", 64'(bus.overflow), 64'd0);
        chk("t6.data", 64'({bus.out_seg_x0, bus.out_seg_y0, bus.out_seg_x1, bus.out_seg_y1}),
            64'd0);
        n_rst = 1'b1;
        tick();
        tick();
        tick();
        chk("t6.no_resume_busy", 64'(bus.busy), 64'd0);
        chk("t6.no_resume_flag", 64'(bus.out_flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
